// File: rtl/ucie_ctl_adapter_sb_cfg_rx.sv
// ucie_ctl_adapter_sb_cfg_rx
// Adapter-side consumer of the RDI sideband config stream. Reassembles NC-bit
// beats into sideband messages (64b header, plus a 64b payload when opcode[0]
// is set), queues completed messages in a small FIFO and returns one credit
// pulse to the PHY for every message drained by the adapter SB handler.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_pl_cfg_vld     beat valid (one beat per cycle high)
//   i_pl_cfg         beat data, LSB-first within a qword
//   o_lp_cfg_crd     one-cycle credit-return pulse, cycle after each pop
//   o_msg_vld        FIFO head valid
//   i_msg_rdy        consumer accept; pop on o_msg_vld & i_msg_rdy
//   o_msg_hdr        head message header
//   o_msg_data       head payload (0 when no payload)
//   o_msg_has_data   head message carries a payload
//   o_err_ovf        sticky overflow flag; a completed message was dropped
module ucie_ctl_adapter_sb_cfg_rx #(
  parameter int unsigned NC    = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pl_cfg_vld,
  input  logic [NC-1:0] i_pl_cfg,
  output logic          o_lp_cfg_crd,
  output logic          o_msg_vld,
  input  logic          i_msg_rdy,
  output logic [63:0]   o_msg_hdr,
  output logic [63:0]   o_msg_data,
  output logic          o_msg_has_data,
  output logic          o_err_ovf
);

  localparam int unsigned BPQ = 64 / NC;
  localparam int unsigned CW  = $clog2(BPQ) + 1;
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW  = ((DEPTH > 1) ? $clog2(DEPTH) : 0) + 1;

  localparam logic [CW-1:0] LastBeat = CW'(BPQ - 1);
  // Pointer XOR pattern for full: MSBs differ, lower bits equal.
  localparam logic [PW-1:0] FullXor  = PW'(1) << (PW - 1);

  typedef enum logic [0:0] {StHdr, StData} state_e;

  // ---------------------------------------------------------------------------
  // Beat assembly
  // ---------------------------------------------------------------------------
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [63:0]   hdr_q, data_q;
  logic [63:0]   hdr_nxt, data_nxt;
  logic          last_beat;

  // Completed message staged for one cycle before it is written to the FIFO.
  logic          push_q;
  logic [63:0]   push_hdr_q, push_data_q;
  logic          push_has_q;

  always_comb begin
    hdr_nxt   = hdr_q;
    data_nxt  = data_q;
    last_beat = i_pl_cfg_vld && (cnt_q == LastBeat);
    for (int unsigned k = 0; k < BPQ; k++) begin
      if (cnt_q == CW'(k)) begin
        hdr_nxt[k*NC +: NC]  = i_pl_cfg;
        data_nxt[k*NC +: NC] = i_pl_cfg;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StHdr;
      cnt_q       <= '0;
      hdr_q       <= '0;
      data_q      <= '0;
      push_q      <= 1'b0;
      push_hdr_q  <= '0;
      push_data_q <= '0;
      push_has_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      if (i_pl_cfg_vld) begin
        cnt_q <= last_beat ? '0 : cnt_q + CW'(1);
        unique case (state_q)
          StHdr: begin
            hdr_q <= hdr_nxt;
            if (last_beat) begin
              // opcode = hdr[4:0]; only its LSB selects a payload.
              if (hdr_nxt[0]) begin
                state_q <= StData;
              end else begin
                push_q      <= 1'b1;
                push_hdr_q  <= hdr_nxt;
                push_data_q <= '0;
                push_has_q  <= 1'b0;
              end
            end
          end
          StData: begin
            data_q <= data_nxt;
            if (last_beat) begin
              push_q      <= 1'b1;
              push_hdr_q  <= hdr_q;
              push_data_q <= data_nxt;
              push_has_q  <= 1'b1;
              state_q     <= StHdr;
            end
          end
          default: state_q <= StHdr;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Message FIFO
  // ---------------------------------------------------------------------------
  logic [63:0]   mem_hdr  [DEPTH];
  logic [63:0]   mem_data [DEPTH];
  logic          mem_has  [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          full, empty, pop, push_ok;
  logic          crd_q, ovf_q;

  always_comb begin
    wr_idx  = (DEPTH > 1) ? wr_ptr_q[IW-1:0] : '0;
    rd_idx  = (DEPTH > 1) ? rd_ptr_q[IW-1:0] : '0;
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = ((wr_ptr_q ^ rd_ptr_q) == FullXor);
    pop     = !empty && i_msg_rdy;
    // A push into a full FIFO still lands if the head leaves this cycle.
    push_ok = push_q && (!full || pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_hdr[i]  <= '0;
        mem_data[i] <= '0;
        mem_has[i]  <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      crd_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_hdr[wr_idx]  <= push_hdr_q;
        mem_data[wr_idx] <= push_data_q;
        mem_has[wr_idx]  <= push_has_q;
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push_q && !push_ok) begin
        ovf_q <= 1'b1;
      end
      crd_q <= pop;
    end
  end

  always_comb begin
    o_msg_vld      = !empty;
    o_msg_hdr      = mem_hdr[rd_idx];
    o_msg_data     = mem_data[rd_idx];
    o_msg_has_data = mem_has[rd_idx];
    o_lp_cfg_crd   = crd_q;
    o_err_ovf      = ovf_q;
  end

endmodule

// File: tb/tb_ucie_ctl_adapter_sb_cfg_rx.sv
// Scoreboard bench for ucie_ctl_adapter_sb_cfg_rx (NC=32, DEPTH=2).
module tb_ucie_ctl_adapter_sb_cfg_rx;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_pl_cfg_vld;
  logic [31:0] i_pl_cfg;
  logic        o_lp_cfg_crd;
  logic        o_msg_vld;
  logic        i_msg_rdy;
  logic [63:0] o_msg_hdr;
  logic [63:0] o_msg_data;
  logic        o_msg_has_data;
  logic        o_err_ovf;

  ucie_ctl_adapter_sb_cfg_rx #(
    .NC   (32),
    .DEPTH(2)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_pl_cfg_vld  (i_pl_cfg_vld),
    .i_pl_cfg      (i_pl_cfg),
    .o_lp_cfg_crd  (o_lp_cfg_crd),
    .o_msg_vld     (o_msg_vld),
    .i_msg_rdy     (i_msg_rdy),
    .o_msg_hdr     (o_msg_hdr),
    .o_msg_data    (o_msg_data),
    .o_msg_has_data(o_msg_has_data),
    .o_err_ovf     (o_err_ovf)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected messages: {hdr, data, has_data}
  logic [128:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%016h, expected 0x%016h (t=%0t)", name, act, req, $time);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d);
    i_pl_cfg_vld = 1'b1;
    i_pl_cfg     = d;
    tick();
    i_pl_cfg_vld = 1'b0;
    i_pl_cfg     = '0;
  endtask

  // Splits a message into LSB-first beats; optional stall before the last payload beat.
  task automatic send_msg(input logic [63:0] hdr, input logic [63:0] data, input logic has,
                          input logic expect_push, input int stall);
    if (expect_push) exp_q.push_back({hdr, (has ? data : 64'h0), has});
    send_beat(hdr[31:0]);
    send_beat(hdr[63:32]);
    if (has) begin
      send_beat(data[31:0]);
      repeat (stall) tick();
      send_beat(data[63:32]);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vld"}, 64'(o_msg_vld), 64'd0);
    check({tag, "_crd"}, 64'(o_lp_cfg_crd), 64'd0);
    check({tag, "_hdr"}, o_msg_hdr, 64'd0);
    check({tag, "_data"}, o_msg_data, 64'd0);
    check({tag, "_has"}, 64'(o_msg_has_data), 64'd0);
    check({tag, "_ovf"}, 64'(o_err_ovf), 64'd0);
  endtask

  // Monitor: compares the head on every handshake and the credit pulse one cycle later.
  logic pop_prev = 1'b0;
  always @(negedge i_clk) begin
    logic [128:0] e;
    if (pop_prev || o_lp_cfg_crd) check("crd_pulse", 64'(o_lp_cfg_crd), 64'(pop_prev));
    pop_prev = i_rst_n && o_msg_vld && i_msg_rdy;
    if (pop_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_msg", o_msg_hdr, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("msg_hdr", o_msg_hdr, e[128:65]);
        check("msg_data", o_msg_data, e[64:1]);
        check("msg_has", 64'(o_msg_has_data), 64'(e[0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    i_rst_n      = 1'b0;
    i_pl_cfg_vld = 1'b0;
    i_pl_cfg     = '0;
    i_msg_rdy    = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    i_rst_n = 1'b1;
    tick();

    // 1) header-only message and its two-cycle latency
    exp_q.push_back({64'hAAAABBBB_00000010, 64'h0, 1'b0});
    send_beat(32'h0000_0010);
    send_beat(32'hAAAA_BBBB);
    @(negedge i_clk);
    check("t1_vld_cycle1", 64'(o_msg_vld), 64'd0);
    tick();
    @(negedge i_clk);
    check("t1_vld_cycle2", 64'(o_msg_vld), 64'd1);
    tick();
    i_msg_rdy = 1'b1;
    drain();

    // 2) message with payload
    exp_q.push_back({64'h00000001_00000011, 64'hCAFEF00D_DEADBEEF, 1'b1});
    send_beat(32'h0000_0011);
    send_beat(32'h0000_0001);
    send_beat(32'hDEAD_BEEF);
    send_beat(32'hCAFE_F00D);
    drain();

    // 5) payload stall gives the same message as the unstalled case
    send_msg(64'h00000002_00000013, 64'h33334444_11112222, 1'b1, 1'b1, 0);
    send_msg(64'h00000002_00000013, 64'h33334444_11112222, 1'b1, 1'b1, 5);
    drain();

    // 4) full FIFO: pop coincides with the push of a third message
    i_msg_rdy = 1'b0;
    send_msg(64'h0000000A_00000002, 64'h0, 1'b0, 1'b1, 0);
    send_msg(64'h0000000B_00000004, 64'h0, 1'b0, 1'b1, 0);
    repeat (3) tick();
    send_msg(64'h0000000C_00000003, 64'h12345678_9ABCDEF0, 1'b1, 1'b1, 0);
    i_msg_rdy = 1'b1;  // head leaves in the same cycle the staged message is written
    tick();
    i_msg_rdy = 1'b0;
    repeat (3) tick();
    check("t4_ovf_clear", 64'(o_err_ovf), 64'd0);
    check("t4_vld", 64'(o_msg_vld), 64'd1);
    i_msg_rdy = 1'b1;
    drain();
    tick();
    check("t4_empty", 64'(o_msg_vld), 64'd0);

    // 3) overflow: third message dropped, sticky flag, no credit
    i_msg_rdy = 1'b0;
    send_msg(64'h00000101_00000006, 64'h0, 1'b0, 1'b1, 0);
    send_msg(64'h00000202_00000007, 64'h55556666_77778888, 1'b1, 1'b1, 0);
    send_msg(64'h00000303_00000008, 64'h0, 1'b0, 1'b0, 0);
    repeat (3) tick();
    check("t3_ovf_set", 64'(o_err_ovf), 64'd1);
    check("t3_no_crd", 64'(o_lp_cfg_crd), 64'd0);
    i_msg_rdy = 1'b1;
    drain();
    repeat (2) tick();
    check("t3_empty", 64'(o_msg_vld), 64'd0);
    check("t3_ovf_sticky", 64'(o_err_ovf), 64'd1);

    // 6) reset after 3 of 4 beats
    i_msg_rdy = 1'b0;
    send_beat(32'h0000_0015);
    send_beat(32'h0000_0009);
    send_beat(32'h1111_2222);
    i_rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    tick();
    i_rst_n = 1'b1;
    tick();
    send_msg(64'h12345678_00000020, 64'h0, 1'b0, 1'b1, 0);
    repeat (2) tick();
    check("t6_vld", 64'(o_msg_vld), 64'd1);
    i_msg_rdy = 1'b1;
    drain();
    repeat (3) tick();
    check("t6_ovf", 64'(o_err_ovf), 64'd0);
    check("final_empty", 64'(o_msg_vld), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
